// File: rtl/clock_div_pkg.sv
// Shared constants and helpers for the programmable clock divider:
// default counter width, write-time clamping of div/high, channel index width.
package clock_div_pkg;

  localparam int CNT_W_DEF = 16;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int ch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

  // Expects the already-clamped divisor so the result always leaves one low cycle.
  function automatic logic [31:0] clamp_high(input logic [31:0] h,
                                             input logic [31:0] d_clamped);
    logic [31:0] r;
    r = h;
    if (h < 32'd1) r = 32'd1;
    else if (h > d_clamped - 32'd1) r = d_clamped - 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: period counter, active and shadow settings, pending flag
// and registered clk_out/tick. New settings only take effect at a period boundary.
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  output logic             pending,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] dbg_cnt
);

  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_DIV - DEFAULT_DIV / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] sdiv_q, sdiv_d;
  logic [CNT_W-1:0] shigh_q, shigh_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] lo;
  logic             last;
  logic             apply;
  logic [31:0]      wr_div_c;
  logic [31:0]      wr_high_c;

  always_comb begin
    lo        = div_q - high_q;
    last      = (cnt_q == div_q - CNT_W'(1));
    wr_div_c  = clamp_div(32'(wr_div));
    wr_high_c = clamp_high(32'(wr_high), wr_div_c);
  end

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    high_d    = high_q;
    sdiv_d    = sdiv_q;
    shigh_d   = shigh_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    tick_d    = tick_q;
    apply     = 1'b0;

    // sync and a disabled channel both park at cnt=0 and may apply immediately.
    if (sync || !en) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
      apply     = pend_q;
    end else begin
      clk_out_d = (cnt_q >= lo);
      tick_d    = (cnt_q == '0);
      if (last) begin
        cnt_d = '0;
        apply = pend_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (apply) begin
      div_d  = sdiv_q;
      high_d = shigh_q;
      pend_d = 1'b0;
    end

    // Writes are only accepted while not pending, so they never race an apply.
    if (wr) begin
      sdiv_d  = wr_div_c[CNT_W-1:0];
      shigh_d = wr_high_c[CNT_W-1:0];
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= RST_DIV;
      high_q    <= RST_HIGH;
      sdiv_q    <= RST_DIV;
      shigh_q   <= RST_HIGH;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      high_q    <= high_d;
      sdiv_q    <= sdiv_d;
      shigh_q   <= shigh_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pending = pend_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign dbg_cnt = cnt_q;

endmodule

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock divider: config write demux, cfg_ready mux
// and one clock_div_chan per channel.
// Handshake: a config write is accepted on an edge where cfg_valid && cfg_ready;
// cfg_ready drops while the addressed channel still holds an unapplied write.
module clock_div_prog
  import clock_div_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = CNT_W_DEF,
  parameter  int DEFAULT_DIV = 5,
  localparam int CH_W        = ch_idx_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr;
  logic [CNT_W-1:0]  dbg_cnt [NUM_CH];

  // Out-of-range channel numbers read as ready and select no channel.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pending[i];
    end
  end

  always_comb begin
    wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clock_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .wr_high (cfg_high),
      .pending (pending[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .dbg_cnt (dbg_cnt[g])
    );
  end

endmodule

// File: doc/clock_div_prog.md
# clock_div_prog

Multi-channel, runtime-programmable integer clock divider. It is the parametrised successor to the fixed single-output divider. Each channel produces a divided, registered clock-enable-style square wave with programmable period and high time. Reprogramming is glitch-free, taking effect only at a period boundary. It sits between the system clock and the peripheral blocks (UART baud, PWM, sampling strobes) that need slow, phase-alignable ticks.

## Interface
- NUM_CH, 4, number of independent divider channels (1..16)
- CNT_W, 16, width of divisor/high-time fields and per-channel counter
- DEFAULT_DIV, 5, divisor loaded into every channel at reset (2..2^CNT_W-1)
- clk_in  input  1  sole clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- en  input  NUM_CH  per-channel run enable
- sync  input  1  one-cycle pulse; restarts all channels in phase
- cfg_valid  input  1  config write request
- cfg_ready  output  1  config write accepted when cfg_valid & cfg_ready
- cfg_ch  input  max(1,$clog2(NUM_CH))  target channel
- cfg_div  input  CNT_W  new period in clk_in cycles
- cfg_high  input  CNT_W  new high time in clk_in cycles
- clk_out  output  NUM_CH  divided outputs, registered
- tick  output  NUM_CH  one-cycle pulse at start of each period, registered

## Operation
- Per channel: active div/high, shadow div/high, pending flag, counter cnt (0..div-1); lo = div - high.
- Enabled channel, each edge: clk_out <= (cnt >= lo); tick <= (cnt == 0); cnt <= (cnt == div-1) ? 0 : cnt+1. The output is low for the first lo cycles, then high for high cycles.
- Clamping is applied on write: div < 2 -> 2; high is clamped to [1, div-1] after the div clamp.
- Config: cfg_ready = !pending[cfg_ch] (combinational). On handshake, the shadow is written and pending is set.
- Apply: at the edge where cnt == div-1 and pending, active <= shadow and pending clears. The next period (cnt=0) uses the new values. A period is never truncated or stretched mid-way.
- en low: cnt held 0, clk_out <= 0, tick <= 0. A pending shadow is applied at the next edge. Config writes are still accepted.
- en rising: the first edge with en high processes cnt=0 (tick=1, clk_out=0).
- sync: at that edge every channel sets cnt <= 0, clk_out <= 0, tick <= 0, and applies any pending shadow. The following edge behaves as the cnt=0 edge. sync overrides the normal count/apply for that edge.
- Write landing on the same edge as a boundary: the value goes to the shadow only and applies at the next boundary.
- cfg_ch >= NUM_CH: cfg_ready=1, the write is dropped.

## Timing
- Reset values: cnt 0; active div DEFAULT_DIV; high DEFAULT_DIV - DEFAULT_DIV/2; pending 0; clk_out 0; tick 0; cfg_ready 1.
- Output latency is one edge from the cnt value to clk_out/tick. With div=5, high=3, en high from reset release, clk_out after edges 0..4 = 0,0,1,1,1; tick = 1,0,0,0,0; repeating.
- Reconfig latency: worst case one full old period plus one cycle.
- rst_n assertion mid-period clears outputs immediately (asynchronous). Deassertion is synchronised externally.
- There is no combinational path from inputs to clk_out/tick. cfg_ready depends combinationally on cfg_ch only.

## Structure
- Package clock_div_pkg: CNT_W default, clamp function for div/high, channel-index width function.
- Sub-module clock_div_chan: one channel (counter, active/shadow, pending, output regs). The top holds the config demux, the cfg_ready mux and a generate loop over NUM_CH.

## Test plan
- Reset release, en=all, DEFAULT_DIV=5 -> every clk_out repeats 0,0,1,1,1; tick every 5 cycles, aligned with the first low cycle.
- Write ch1 div=8 high=4 mid-period -> the old 5-cycle period completes, then exactly 4 low and 4 high cycles. cfg_ready for ch1 is low until the apply edge.
- Write div=0 high=0 to ch2 -> clamped to div=2 high=1, giving clk_out alternating 0,1.
- Drop en[0] mid-high phase -> clk_out[0]=0 next edge. Re-raise -> tick[0]=1 on the first edge, then the normal pattern.
- ch0 div=4, ch3 div=6, pulse sync -> both restart the edge after sync with coincident ticks. Ticks coincide again after 12 cycles.
- Assert rst_n low during a pending write -> outputs 0 asynchronously, pending cleared, and after release the DEFAULT_DIV pattern resumes.
